// File: rtl/spi_master_pkg.sv
// Shared defaults, FSM state type and a small helper for the SPI master.
package spi_master_pkg;

    localparam int unsigned SpiWidth   = 16;
    localparam int unsigned SpiClkDiv  = 2;
    localparam int unsigned SpiCsSetup = 2;
    localparam int unsigned SpiCsHold  = 2;
    localparam int unsigned SpiCsIdle  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
    } spi_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider: toggles the SCK level every CLK_DIV cycles while enabled and
// flags the cycle on which SCK rises or falls. Forced low when disabled.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clkIN,
    input  logic reset_spi,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);

    logic [CntW-1:0] cnt_q;
    logic            sck_q;
    logic            tick;

    assign tick = en_i && (cnt_q == CntW'(CLK_DIV - 1));

    always_ff @(posedge clkIN) begin
        if (!reset_spi) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = tick && !sck_q;
    assign fall_o = tick && sck_q;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with chip-select setup/hold/idle gaps.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned WIDTH    = SpiWidth,
    parameter int unsigned CLK_DIV  = SpiClkDiv,
    parameter int unsigned CS_SETUP = SpiCsSetup,
    parameter int unsigned CS_HOLD  = SpiCsHold,
    parameter int unsigned CS_IDLE  = SpiCsIdle
) (
    input  logic             clkIN,
    input  logic             reset_spi,
    input  logic             startIN,
    input  logic [WIDTH-1:0] dataIN,
    output logic [WIDTH-1:0] dataOUT,
    output logic             busyOUT,
    output logic             doneOUT,
    output logic             nSSOUT,
    output logic             SCKOUT,
    output logic             MOSIOUT,
    input  logic             MISOIN
);

    localparam int unsigned PhW = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    spi_state_e       state_q;
    logic [PhW-1:0]   ph_cnt_q;
    logic [4:0]       bit_cnt_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] data_out_q;
    logic             busy_q;
    logic             done_q;
    logic             nss_q;
    logic             sck_en;
    logic             sck_rise;
    logic             sck_fall;

    assign sck_en = (state_q == StXfer);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clkIN    (clkIN),
        .reset_spi(reset_spi),
        .en_i     (sck_en),
        .sck_o    (SCKOUT),
        .rise_o   (sck_rise),
        .fall_o   (sck_fall)
    );

    always_ff @(posedge clkIN) begin
        if (!reset_spi) begin
            state_q    <= StIdle;
            ph_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nss_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (startIN) begin
                        tx_q      <= dataIN;
                        nss_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ph_cnt_q  <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (ph_cnt_q == PhW'(CS_SETUP - 1)) begin
                        ph_cnt_q <= '0;
                        state_q  <= StXfer;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PhW'(1);
                    end
                end
                StXfer: begin
                    if (sck_rise) begin
                        rx_q <= {rx_q[WIDTH-2:0], MISOIN};
                    end
                    // The top bit of tx_q drives MOSI, so it keeps the LSB after the last bit.
                    if (sck_fall) begin
                        if (bit_cnt_q == 5'(WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= StHold;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            tx_q      <= {tx_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (ph_cnt_q == PhW'(CS_HOLD - 1)) begin
                        ph_cnt_q   <= '0;
                        nss_q      <= 1'b1;
                        data_out_q <= rx_q;
                        done_q     <= 1'b1;
                        state_q    <= StGap;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PhW'(1);
                    end
                end
                StGap: begin
                    if (ph_cnt_q == PhW'(CS_IDLE - 1)) begin
                        ph_cnt_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PhW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dataOUT = data_out_q;
    assign busyOUT = busy_q;
    assign doneOUT = done_q;
    assign nSSOUT  = nss_q;
    assign MOSIOUT = tx_q[WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, loopback, slave model, ignored start, back-to-back, abort.
module tb_spi_master;

    logic        clk;
    logic        rst;
    logic        start1, start2;
    logic [15:0] din1, din2, dout1, dout2;
    logic        busy1, busy2, done1, done2, nss1, nss2, sck1, sck2, mosi1, mosi2;
    logic        miso1, miso2;
    logic        loop1;

    logic [15:0] sl_preload, sl_shift, sl_rx;
    logic        nss_prev, sck_prev;

    int n_vec = 0;
    int n_err = 0;

    spi_master #(
        .WIDTH(16), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)
    ) dut1 (
        .clkIN(clk), .reset_spi(rst), .startIN(start1), .dataIN(din1), .dataOUT(dout1),
        .busyOUT(busy1), .doneOUT(done1), .nSSOUT(nss1), .SCKOUT(sck1), .MOSIOUT(mosi1),
        .MISOIN(miso1)
    );

    spi_master #(
        .WIDTH(16), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)
    ) dut2 (
        .clkIN(clk), .reset_spi(rst), .startIN(start2), .dataIN(din2), .dataOUT(dout2),
        .busyOUT(busy2), .doneOUT(done2), .nSSOUT(nss2), .SCKOUT(sck2), .MOSIOUT(mosi2),
        .MISOIN(miso2)
    );

    assign miso1 = loop1 ? mosi1 : sl_shift[15];
    assign miso2 = mosi2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: loads its word when nSS falls, shifts on SCK fall, captures MOSI on SCK rise.
    always @(posedge clk) begin
        nss_prev <= nss1;
        sck_prev <= sck1;
        if (nss_prev && !nss1) sl_shift <= sl_preload;
        else if (sck_prev && !sck1) sl_shift <= {sl_shift[14:0], 1'b0};
        if (!sck_prev && sck1) sl_rx <= {sl_rx[14:0], mosi1};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input bit which, input logic [15:0] d);
        if (which) begin din2 = d; start2 = 1'b1; end
        else begin din1 = d; start1 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Samples one DUT for 'budget' cycles after the accepting edge.
    task automatic run(input bit which, input int budget, output int done_t, output int rises,
                       output int dones, output int viol, output int period);
        logic s, n, d, prev;
        int   r1;
        done_t = -1; rises = 0; dones = 0; viol = 0; period = -1; prev = 1'b0; r1 = -1;
        for (int t = 1; t <= budget; t++) begin
            @(posedge clk); #1;
            s = which ? sck2 : sck1;
            n = which ? nss2 : nss1;
            d = which ? done2 : done1;
            if (s && !prev) begin
                rises++;
                if (rises == 1) r1 = t;
                if (rises == 2) period = t - r1;
            end
            if (s && n) viol++;
            if (d) begin
                dones++;
                if (done_t < 0) done_t = t;
            end
            prev = s;
        end
    endtask

    int done_t, rises, dones, viol, period, dones2, got, nh, bl;
    logic prv;

    initial begin
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; din1 = '0; din2 = '0; loop1 = 1'b1;
        sl_preload = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_nss", nss1, 1); chk("reset_sck", sck1, 0); chk("reset_mosi", mosi1, 0);
        chk("reset_busy", busy1, 0); chk("reset_done", done1, 0); chk("reset_dout", dout1, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Loopback
        kick(0, 16'hA5C3);
        chk("lb_busy", busy1, 1); chk("lb_nss", nss1, 0); chk("lb_mosi_msb", mosi1, 1);
        run(0, 75, done_t, rises, dones, viol, period);
        chk("lb_done_t", done_t, 68); chk("lb_rises", rises, 16); chk("lb_dones", dones, 1);
        chk("lb_viol", viol, 0); chk("lb_period", period, 4); chk("lb_dout", dout1, 16'hA5C3);
        chk("lb_idle", busy1, 0);

        // Slave model exchange
        loop1 = 1'b0; sl_preload = 16'hBEEF;
        kick(0, 16'h1234);
        run(0, 75, done_t, rises, dones, viol, period);
        chk("sl_done_t", done_t, 68); chk("sl_rx", sl_rx, 16'h1234);
        chk("sl_dout", dout1, 16'hBEEF);

        // Start during XFER is ignored
        sl_preload = 16'h0F0F;
        kick(0, 16'h3C96);
        run(0, 20, done_t, rises, dones, viol, period);
        kick(0, 16'hFFFF);
        run(0, 100, done_t, rises, dones2, viol, period);
        chk("ign_dones", dones + dones2, 1); chk("ign_rx", sl_rx, 16'h3C96);
        chk("ign_dout", dout1, 16'h0F0F); chk("ign_nss", nss1, 1); chk("ign_busy", busy1, 0);

        // Back-to-back with start held high
        sl_preload = 16'h0000;
        din1 = 16'h0001; start1 = 1'b1;
        @(posedge clk); #1;
        din1 = 16'h8000;
        got = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (done1) begin got = 1; break; end
        end
        chk("b2b_done1", got, 1); chk("b2b_word1", sl_rx, 16'h0001);
        nh = 0; bl = 0;
        for (int t = 0; t < 20; t++) begin
            if (!nss1) break;
            nh++;
            if (!busy1) bl++;
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        chk("b2b_nss_high", nh, 3); chk("b2b_busy_low", bl, 1);
        got = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (done1) begin got = 1; break; end
        end
        chk("b2b_done2", got, 1); chk("b2b_word2", sl_rx, 16'h8000);
        chk("b2b_dout", dout1, 16'h0000);
        repeat (4) @(posedge clk);
        #1;

        // Abort with reset after the 5th SCK rise
        loop1 = 1'b1;
        kick(0, 16'h0F0F);
        rises = 0; prv = 1'b0;
        for (int t = 0; t < 100 && rises < 5; t++) begin
            @(posedge clk); #1;
            if (sck1 && !prv) rises++;
            prv = sck1;
        end
        chk("abort_rise5", rises, 5); chk("abort_sck_hi", sck1, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_nss", nss1, 1); chk("abort_sck", sck1, 0); chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0); chk("abort_dout", dout1, 0);
        rst = 1'b1;
        run(0, 10, done_t, rises, dones, viol, period);
        chk("abort_nodone", dones, 0);
        kick(0, 16'h5A5A);
        run(0, 75, done_t, rises, dones, viol, period);
        chk("post_done_t", done_t, 68); chk("post_dout", dout1, 16'h5A5A);
        chk("post_rises", rises, 16);

        // CLK_DIV=1 instance
        kick(1, 16'hC35A);
        run(1, 45, done_t, rises, dones, viol, period);
        chk("div1_done_t", done_t, 36); chk("div1_rises", rises, 16);
        chk("div1_period", period, 2); chk("div1_dout", dout2, 16'hC35A);
        chk("div1_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
